// File: rtl/uart_tx_sched_if.sv
// Requester-side and UART-side handshake bundle for uart_tx_sched.
// master = the scheduler's view, slave = the requesters/UART's view.
`timescale 1ns/1ps
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_done;

    modport master (
        input  req, req_data, req_last, tx_done,
        output req_ack, grant, tx_start, tx_data
    );

    modport slave (
        output req, req_data, req_last, tx_done,
        input  req_ack, grant, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter that lends one UART transmitter to NUM_REQ byte streams,
// one frame per grant, with a per-grant byte cap and a tx_done watchdog.
`timescale 1ns/1ps
module uart_tx_sched #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_FRAME = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_sched_if.master bus,
    output logic            busy,
    output logic            frame_done,
    output logic            tx_err
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   gidx_reg, gidx_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [7:0]         byte_cnt_reg, byte_cnt_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic               last_reg, last_next;
    logic [NUM_REQ-1:0] req_ack_reg, req_ack_next;
    logic               tx_start_reg, tx_start_next;
    logic [7:0]         tx_data_reg, tx_data_next;
    logic               frame_done_reg, frame_done_next;
    logic               tx_err_reg, tx_err_next;
    logic               busy_reg, busy_next;

    // Candidate gi is the requester (ptr+1+gi) mod NUM_REQ, so candidate 0
    // is the one right after the last-served requester.
    logic [7:0]         req_byte  [NUM_REQ];
    logic [IDX_W-1:0]   cand_idx  [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        logic [IDX_W:0] wrapped;
        assign req_byte[gi]  = bus.req_data[8*gi +: 8];
        assign sum           = {1'b0, ptr_reg} + (IDX_W+1)'(gi + 1);
        assign wrapped       = (sum >= (IDX_W+1)'(NUM_REQ)) ? sum - (IDX_W+1)'(NUM_REQ) : sum;
        assign cand_idx[gi]  = wrapped[IDX_W-1:0];
        assign cand_hit[gi]  = bus.req[cand_idx[gi]];
    end

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

    always_comb begin
        pick_valid = |cand_hit;
        pick_idx   = '0;
        // Descending scan so the lowest circular offset wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                pick_idx = cand_idx[k];
            end
        end
    end

    assign pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;

    logic [7:0] sel_data;
    logic       sel_last;
    logic       sel_req;

    assign sel_data = req_byte[gidx_reg];
    assign sel_last = bus.req_last[gidx_reg];
    assign sel_req  = bus.req[gidx_reg];

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        gidx_next       = gidx_reg;
        grant_next      = grant_reg;
        byte_cnt_next   = byte_cnt_reg;
        timer_next      = timer_reg;
        last_next       = last_reg;
        req_ack_next    = '0;
        tx_start_next   = 1'b0;
        tx_data_next    = tx_data_reg;
        frame_done_next = 1'b0;
        tx_err_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (pick_valid) begin
                    state_next    = S_LOAD;
                    gidx_next     = pick_idx;
                    grant_next    = pick_onehot;
                    byte_cnt_next = '0;
                end
            end
            S_LOAD: begin
                tx_data_next  = sel_data;
                tx_start_next = 1'b1;
                req_ack_next  = grant_reg;
                last_next     = sel_last;
                byte_cnt_next = byte_cnt_reg + 8'd1;
                timer_next    = '0;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                // tx_done is checked first so it beats a same-edge timeout.
                if (bus.tx_done) begin
                    if (last_reg || (byte_cnt_reg == 8'(MAX_FRAME)) || !sel_req) begin
                        frame_done_next = 1'b1;
                        grant_next      = '0;
                        ptr_next        = gidx_reg;
                        state_next      = S_IDLE;
                    end else begin
                        state_next = S_LOAD;
                    end
                end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
                    tx_err_next = 1'b1;
                    grant_next  = '0;
                    ptr_next    = gidx_reg;
                    state_next  = S_IDLE;
                end else if (timer_reg != {TMR_W{1'b1}}) begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                grant_next = '0;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            ptr_reg        <= IDX_W'(NUM_REQ - 1);
            gidx_reg       <= '0;
            grant_reg      <= '0;
            byte_cnt_reg   <= '0;
            timer_reg      <= '0;
            last_reg       <= 1'b0;
            req_ack_reg    <= '0;
            tx_start_reg   <= 1'b0;
            tx_data_reg    <= 8'h00;
            frame_done_reg <= 1'b0;
            tx_err_reg     <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            gidx_reg       <= gidx_next;
            grant_reg      <= grant_next;
            byte_cnt_reg   <= byte_cnt_next;
            timer_reg      <= timer_next;
            last_reg       <= last_next;
            req_ack_reg    <= req_ack_next;
            tx_start_reg   <= tx_start_next;
            tx_data_reg    <= tx_data_next;
            frame_done_reg <= frame_done_next;
            tx_err_reg     <= tx_err_next;
            busy_reg       <= busy_next;
        end
    end

    assign bus.req_ack  = req_ack_reg;
    assign bus.grant    = grant_reg;
    assign bus.tx_start = tx_start_reg;
    assign bus.tx_data  = tx_data_reg;
    assign busy         = busy_reg;
    assign frame_done   = frame_done_reg;
    assign tx_err       = tx_err_reg;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: dut_a (cap 16) and dut_b (cap 3), both TIMEOUT=16,
// share stimulus; sel picks which one is observed and receives tx_done.
`timescale 1ns/1ps
module tb_uart_tx_sched;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.NUM_REQ(N)) bus_a ();
    uart_tx_sched_if #(.NUM_REQ(N)) bus_b ();
    logic busy_a, fd_a, err_a, busy_b, fd_b, err_b;

    uart_tx_sched #(.NUM_REQ(N), .MAX_FRAME(16), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.master),
        .busy(busy_a), .frame_done(fd_a), .tx_err(err_a)
    );
    uart_tx_sched #(.NUM_REQ(N), .MAX_FRAME(3), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.master),
        .busy(busy_b), .frame_done(fd_b), .tx_err(err_b)
    );

    logic           sel = 1'b0;
    logic [N-1:0]   req_v = '0;
    logic [8*N-1:0] data_v = '0;
    logic [N-1:0]   last_v = '0;
    logic           done_v = 1'b0;

    assign bus_a.req      = req_v;
    assign bus_a.req_data = data_v;
    assign bus_a.req_last = last_v;
    assign bus_a.tx_done  = done_v & ~sel;
    assign bus_b.req      = req_v;
    assign bus_b.req_data = data_v;
    assign bus_b.req_last = last_v;
    assign bus_b.tx_done  = done_v & sel;

    logic [N-1:0] o_grant, o_ack;
    logic         o_start, o_busy, o_fd, o_err;
    logic [7:0]   o_data;
    assign o_grant = sel ? bus_b.grant    : bus_a.grant;
    assign o_ack   = sel ? bus_b.req_ack  : bus_a.req_ack;
    assign o_start = sel ? bus_b.tx_start : bus_a.tx_start;
    assign o_data  = sel ? bus_b.tx_data  : bus_a.tx_data;
    assign o_busy  = sel ? busy_b : busy_a;
    assign o_fd    = sel ? fd_b   : fd_a;
    assign o_err   = sel ? err_b  : err_a;

    // Requester models
    logic [7:0] mem [N][8];
    int  len [N];
    int  idx [N];
    int  wd  [N];
    int  acks[N];
    bit  en  [N];
    bit  has_last[N];
    bit  rep [N];
    int  dly, dcnt, cyc;

    // Event logs
    logic [7:0]   st_data[$];
    int           st_gnt[$];
    int           st_cyc[$];
    int           gnt_log[$];
    int           fd_cnt, err_cnt, fd_cyc, err_cyc, ack_mis, end_bad;
    logic [N-1:0] prev_grant;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int idx_of(input logic [N-1:0] g);
        int r = -1;
        for (int i = 0; i < N; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic update_drive();
        for (int i = 0; i < N; i++) begin
            req_v[i]          = en[i] && (idx[i] < len[i]) && !(wd[i] > 0 && acks[i] >= wd[i]);
            data_v[8*i +: 8]  = mem[i][idx[i] % 8];
            last_v[i]         = has_last[i] && (idx[i] == len[i] - 1);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b0; len[i] = 0; idx[i] = 0; wd[i] = 0; acks[i] = 0;
            has_last[i] = 1'b0; rep[i] = 1'b0;
            for (int j = 0; j < 8; j++) mem[i][j] = 8'h00;
        end
        st_data.delete(); st_gnt.delete(); st_cyc.delete(); gnt_log.delete();
        fd_cnt = 0; err_cnt = 0; fd_cyc = 0; err_cyc = 0;
        dcnt = 0; done_v = 1'b0; prev_grant = '0;
        update_drive();
    endtask

    // One clock: observe after the edge, then play requesters and the UART.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        done_v = 1'b0;
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) done_v = 1'b1;
        end
        if (o_start) begin
            st_data.push_back(o_data);
            st_gnt.push_back(idx_of(o_grant));
            st_cyc.push_back(cyc);
            if (dly > 0) dcnt = dly;
        end
        if (o_ack !== (o_start ? o_grant : '0)) ack_mis++;
        for (int i = 0; i < N; i++) begin
            if (o_ack[i]) begin
                acks[i]++;
                idx[i]++;
                if (rep[i] && idx[i] >= len[i]) idx[i] = 0;
            end
        end
        if (o_grant != '0 && prev_grant == '0) gnt_log.push_back(idx_of(o_grant));
        prev_grant = o_grant;
        if (o_fd) begin
            fd_cnt++; fd_cyc = cyc;
            if (o_grant != '0 || o_busy) end_bad++;
        end
        if (o_err) begin
            err_cnt++; err_cyc = cyc;
            if (o_grant != '0 || o_busy) end_bad++;
        end
        update_drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        step();
        step();
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        logic [7:0] exp1 [4];
        logic [7:0] exp3 [7];
        int         gexp3 [7];
        exp1  = '{8'h41, 8'h55, 8'h66, 8'h7A};
        exp3  = '{8'hC1, 8'hC2, 8'hC3, 8'hD1, 8'hD2, 8'hC4, 8'hC5};
        gexp3 = '{2, 2, 2, 3, 3, 2, 2};
        cyc = 0; ack_mis = 0; end_bad = 0; dly = 0;

        // Reset state
        clear_model();
        step();
        step();
        check("reset_grant",    32'(o_grant), 0);
        check("reset_ack",      32'(o_ack),   0);
        check("reset_tx_start", 32'(o_start), 0);
        check("reset_tx_data",  32'(o_data),  0);
        check("reset_busy",     32'(o_busy),  0);
        check("reset_fd",       32'(o_fd),    0);
        check("reset_err",      32'(o_err),   0);
        rst = 1'b0;
        $display("reset checks done");

        // Single frame from requester 1, tx_done 10 cycles after each start
        mem[1][0] = 8'h41; mem[1][1] = 8'h55; mem[1][2] = 8'h66; mem[1][3] = 8'h7A;
        len[1] = 4; has_last[1] = 1'b1; en[1] = 1'b1; dly = 10;
        update_drive();
        step();
        check("lat_grant",    32'(o_grant), 32'(4'b0010));
        check("lat_busy",     32'(o_busy),  1);
        check("lat_no_start", 32'(o_start), 0);
        step();
        check("lat_start",    32'(o_start), 1);
        check("lat_ack",      32'(o_ack),   32'(4'b0010));
        check("lat_data",     32'(o_data),  32'h41);
        for (int k = 0; k < 200 && fd_cnt < 1; k++) step();
        check("single_fd_cnt", 32'(fd_cnt), 1);
        check("single_grant_idle", 32'(o_grant), 0);
        check("single_busy_idle",  32'(o_busy),  0);
        check("single_starts", 32'(st_data.size()), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("single_data%0d", k), 32'(st_data[k]), 32'(exp1[k]));
            check($sformatf("single_gnt%0d", k),  32'(st_gnt[k]),  1);
        end
        check("single_acks", 32'(acks[1]), 4);
        check("b2b_gap", 32'(st_cyc[1] - st_cyc[0]), 12);
        for (int k = 0; k < 5; k++) step();
        check("single_no_err", 32'(err_cnt), 0);
        $display("single frame: %0d starts, %0d frame_done", st_data.size(), fd_cnt);

        // Round-robin: all four requesters stream 2-byte frames
        do_reset();
        for (int i = 0; i < N; i++) begin
            mem[i][0] = 8'(16 * i); mem[i][1] = 8'(16 * i + 1);
            len[i] = 2; has_last[i] = 1'b1; rep[i] = 1'b1; en[i] = 1'b1;
        end
        dly = 3;
        update_drive();
        for (int k = 0; k < 600 && gnt_log.size() < 8; k++) step();
        check("rr_grants", 32'(gnt_log.size()), 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("rr_order%0d", k), 32'(gnt_log[k]), 32'(k % 4));
        check("rr_req1_byte0", 32'(st_data[2]), 32'h10);
        check("rr_req3_byte1", 32'(st_data[7]), 32'h31);
        $display("round robin: %0d grants logged", gnt_log.size());

        // Byte cap (dut_b, MAX_FRAME=3): req2 5 bytes, req3 2 bytes
        sel = 1'b1;
        do_reset();
        for (int j = 0; j < 5; j++) mem[2][j] = 8'hC1 + 8'(j);
        mem[3][0] = 8'hD1; mem[3][1] = 8'hD2;
        len[2] = 5; has_last[2] = 1'b1; en[2] = 1'b1;
        len[3] = 2; has_last[3] = 1'b1; en[3] = 1'b1;
        dly = 2;
        update_drive();
        for (int k = 0; k < 400 && fd_cnt < 3; k++) step();
        check("cap_fd_cnt", 32'(fd_cnt), 3);
        check("cap_starts", 32'(st_data.size()), 7);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("cap_data%0d", k), 32'(st_data[k]), 32'(exp3[k]));
            check($sformatf("cap_gnt%0d", k),  32'(st_gnt[k]),  32'(gexp3[k]));
        end
        check("cap_no_err", 32'(err_cnt), 0);
        $display("cap: %0d starts, %0d frame_done", st_data.size(), fd_cnt);
        sel = 1'b0;

        // Timeout: tx_done withheld for req0's first byte
        do_reset();
        mem[0][0] = 8'hE0; mem[0][1] = 8'hE1; len[0] = 2; has_last[0] = 1'b1; en[0] = 1'b1;
        mem[1][0] = 8'hF0; len[1] = 1; has_last[1] = 1'b1; en[1] = 1'b1;
        dly = 0;
        update_drive();
        for (int k = 0; k < 100 && err_cnt < 1; k++) step();
        check("to_err_cnt", 32'(err_cnt), 1);
        check("to_err_delay", 32'(err_cyc - st_cyc[0]), 16);
        check("to_grant_idle", 32'(o_grant), 0);
        check("to_no_fd", 32'(fd_cnt), 0);
        dly = 5;
        for (int k = 0; k < 100 && fd_cnt < 1; k++) step();
        check("to_next_fd", 32'(fd_cnt), 1);
        check("to_next_gnt", 32'(gnt_log[1]), 1);
        check("to_next_data", 32'(st_data[1]), 32'hF0);
        $display("timeout: tx_err after %0d cycles", err_cyc - st_cyc[0]);

        // tx_done on the timeout edge wins
        do_reset();
        mem[1][0] = 8'h31; mem[1][1] = 8'h32; len[1] = 2; has_last[1] = 1'b1; en[1] = 1'b1;
        dly = 15;
        update_drive();
        for (int k = 0; k < 200 && fd_cnt < 1; k++) step();
        check("edge_fd_cnt", 32'(fd_cnt), 1);
        check("edge_no_err", 32'(err_cnt), 0);
        check("edge_starts", 32'(st_data.size()), 2);
        check("edge_data1",  32'(st_data[1]), 32'h32);
        $display("done-vs-timeout: %0d tx_err, %0d frame_done", err_cnt, fd_cnt);

        // Reset mid-byte
        do_reset();
        mem[2][0] = 8'h51; mem[2][1] = 8'h52; len[2] = 2; has_last[2] = 1'b1; en[2] = 1'b1;
        dly = 10;
        update_drive();
        for (int k = 0; k < 5; k++) step();
        check("mid_busy_before", 32'(o_busy), 1);
        rst = 1'b1;
        step();
        check("mid_rst_grant",    32'(o_grant), 0);
        check("mid_rst_busy",     32'(o_busy),  0);
        check("mid_rst_tx_data",  32'(o_data),  0);
        check("mid_rst_tx_start", 32'(o_start), 0);
        check("mid_rst_ack",      32'(o_ack),   0);
        check("mid_rst_fd",       32'(o_fd),    0);
        rst = 1'b0;
        clear_model();
        mem[0][0] = 8'h01; len[0] = 1; has_last[0] = 1'b1; en[0] = 1'b1;
        mem[2][0] = 8'h02; len[2] = 1; has_last[2] = 1'b1; en[2] = 1'b1;
        update_drive();
        step();
        check("mid_first_grant", 32'(o_grant), 32'(4'b0001));
        $display("reset mid-byte: first grant %b", o_grant);

        // Withdrawal after 2nd byte, no last
        do_reset();
        for (int j = 0; j < 4; j++) mem[0][j] = 8'h61 + 8'(j);
        len[0] = 4; wd[0] = 2; en[0] = 1'b1;
        dly = 4;
        update_drive();
        for (int k = 0; k < 200 && fd_cnt < 1; k++) step();
        for (int k = 0; k < 20; k++) step();
        check("wd_fd_cnt", 32'(fd_cnt), 1);
        check("wd_starts", 32'(st_data.size()), 2);
        check("wd_acks",   32'(acks[0]), 2);
        check("wd_no_err", 32'(err_cnt), 0);
        $display("withdrawal: %0d starts, %0d frame_done", st_data.size(), fd_cnt);

        check("ack_with_start", 32'(ack_mis), 0);
        check("end_pulse_idle", 32'(end_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte-stream requesters. It grants the transmitter to one requester for a whole frame, which ends on `req_last` or on a per-grant byte cap. It then feeds the frame's bytes one at a time over the `uart` TX start/done handshake. It sits between the board's message sources (button/test sequencers, status reporters) and the `uart` instance, replacing ad-hoc per-source TX state machines.

## Interface
- `NUM_REQ`, 4 — number of requesters (2..8)
- `MAX_FRAME`, 16 — maximum bytes per grant before forced hand-over (1..255)
- `TIMEOUT`, 4096 — clock cycles allowed in WAIT for `tx_done` before the frame is aborted (≥2)

- `clk` in 1 — system clock, all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `req` in NUM_REQ — requester i has a byte ready; held high for the whole frame
- `req_data` in 8*NUM_REQ — packed bytes, requester i at [8i+7:8i]
- `req_last` in NUM_REQ — requester i's current byte is the frame's last
- `req_ack` out NUM_REQ — one-cycle pulse: requester i's current byte taken; the requester presents its next byte/last within 2 cycles
- `grant` out NUM_REQ — one-hot current owner, all-zero when idle
- `tx_start` out 1 — one-cycle pulse to `uart` TX
- `tx_data` out 8 — byte to transmit, stable from `tx_start` until the next `tx_start`
- `tx_done` in 1 — one-cycle pulse from `uart` when the byte is fully shifted out
- `busy` out 1 — high whenever state ≠ S_IDLE
- `frame_done` out 1 — one-cycle pulse when a grant ends normally (last, cap, or requester withdrawal)
- `tx_err` out 1 — one-cycle pulse on timeout abort

## Operation
- States: S_IDLE, S_LOAD, S_WAIT; 2-bit encoding; all outputs registered.
- S_IDLE, when any `req` is high:
  - Pick the first requester with `req` high, searching circularly from `ptr+1`. `ptr` is the last-served index and resets to NUM_REQ-1, so requester 0 has first priority.
  - Set `grant` to that requester one-hot, clear `byte_cnt`, go to S_LOAD.
- S_LOAD (exactly one cycle):
  - Drive `tx_data`, `tx_start`, `req_ack[g]` from requester g.
  - Latch `last_r` ← `req_last[g]`, `byte_cnt` ← `byte_cnt+1`, clear the timer, go to S_WAIT.
- S_WAIT: increment the timer each cycle. When `tx_done` arrives:
  - If `last_r`, or `byte_cnt == MAX_FRAME`, or `req[g]` is low: pulse `frame_done`, clear `grant`, `ptr` ← g, go to S_IDLE.
  - Otherwise go to S_LOAD.
- Timeout: timer reaches TIMEOUT-1 in S_WAIT with no `tx_done`:
  - Pulse `tx_err`, clear `grant`, `ptr` ← g, go to S_IDLE. No `frame_done`.
- A cap-forced hand-over does not drop data. The requester keeps `req` high and resumes at its next grant with its unsent byte.
- `req` deasserting in S_IDLE or S_LOAD is ignored until the next S_WAIT decision. A byte already in S_LOAD is always sent.
- `tx_done` outside S_WAIT is ignored.
- `byte_cnt` is 8 bits. The timer is clog2(TIMEOUT) bits and saturates; it never wraps.

## Timing
- Reset values: `grant`=0, `req_ack`=0, `tx_start`=0, `tx_data`=8'h00, `busy`=0, `frame_done`=0, `tx_err`=0, state=S_IDLE, `ptr`=NUM_REQ-1, counters 0.
- Reset mid-frame returns everything to the reset values on the next edge; the partial frame is dropped silently.
- Latency from a `req` sampled high at edge E0 in S_IDLE:
  - `grant` is valid after E0.
  - `tx_start` and `req_ack` pulse in the cycle after E1.
- Back-to-back bytes: `tx_done` sampled at edge Ek → next `tx_start` in the cycle after Ek+1.
- `tx_start` and `req_ack[g]` always coincide and last exactly one cycle.
- `frame_done` or `tx_err` coincides with the first cycle where `grant`=0 and `busy`=0.
- After a grant ends, arbitration resumes on the following edge (one idle cycle minimum between frames).
- `tx_done` and timeout on the same edge: `tx_done` wins, no `tx_err`.

## Test plan
- Single frame: requester 1 sends 8'h41, 8'h55, 8'h66, 8'h7A with `last` on the 4th; `tx_done` 10 cycles after each `tx_start`.
  - Expect 4 `tx_start` pulses with `tx_data` A, U, f, z, 4 `req_ack[1]` pulses, one `frame_done`, and `grant` back to 0.
- Round-robin fairness: all 4 requesters continuously requesting 2-byte frames.
  - Expect grant order 0, 1, 2, 3, 0, … with no requester served twice in a row.
- Cap: `MAX_FRAME`=3; requester 2 sends a 5-byte frame while requester 3 is also requesting.
  - Expect 3 bytes from req2, then `frame_done`, then a req3 frame, then req2's remaining 2 bytes (4th and 5th in order).
- Timeout: `TIMEOUT`=16, `tx_done` withheld after the first `tx_start`.
  - Expect a `tx_err` pulse exactly 16 cycles after entering S_WAIT, no `frame_done`, `grant`=0, and the next requester served.
- Simultaneous events:
  - `tx_done` on the timeout cycle → no `tx_err`, frame continues.
  - `rst` asserted mid-byte → all outputs at reset values on the next cycle, and the first grant after release goes to requester 0.
- Withdrawal: requester 0 drops `req` after its 2nd byte (`last` never set).
  - Expect `frame_done` on the 2nd `tx_done` and no 3rd `tx_start`.
